chanmux_sched: RTL and testbench

CHANMUX_SCHED -- requirements
Module: chanmux_sched

---
 rtl/chanmux_sched.sv | 138 +++++++++++++
 tb/tb_chanmux_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chanmux_sched.sv
// Round-robin packet multiplexer: NUM_CH streaming channels onto one output,
// with a settings-bus channel-enable mask and packets-per-grant burst length.
module chanmux_sched #(
  parameter int         NUM_CH     = 4,
  parameter int         WIDTH      = 32,
  parameter logic [7:0] SR_CH_MASK = 8'd128,
  parameter logic [7:0] SR_BURST   = 8'd129
) (
  input  logic                    ce_clk,
  input  logic                    ce_rst_n,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [NUM_CH*WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]       s_tlast,
  input  logic [NUM_CH-1:0]       s_tvalid,
  output logic [NUM_CH-1:0]       s_tready,
  output logic [WIDTH-1:0]        m_tdata,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [2:0]              m_tuser,
  output logic [31:0]             pkt_count
);

  // state | meaning
  // IDLE  | no grant; picks next requester after last_sel
  // PASS  | channel sel owns the output until its burst ends
  typedef enum logic {IDLE, PASS} state_t;

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SEL_W:0] NCH_W = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W:0] ONE_W = (SEL_W+1)'(1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d, last_q, last_d, pick;
  logic [7:0]          bcnt_q, bcnt_d, burst_q;
  logic [NUM_CH-1:0]   mask_q, req;
  logic [2*NUM_CH-1:0] rot;
  logic [SEL_W:0]      shamt, off, pick_sum;
  logic [31:0]         pkt_d;
  logic [8:0]          bcnt_inc, burst_eff;
  logic                found, beat_end;
  logic [WIDTH-1:0]    ch_data [NUM_CH];
  logic                unused_set_bits;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_split
    assign ch_data[k] = s_tdata[k*WIDTH +: WIDTH];
  end

  assign unused_set_bits = ^set_data[31:8];

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      mask_q  <= '1;
      burst_q <= 8'd1;
    end else if (set_stb) begin
      if (set_addr == SR_CH_MASK) mask_q  <= set_data[NUM_CH-1:0];
      if (set_addr == SR_BURST)   burst_q <= set_data[7:0];
    end
  end

  // Rotate requests so bit 0 is the channel just after last_sel; lowest set bit wins.
  always_comb begin
    req   = s_tvalid & mask_q;
    found = |req;
    shamt = {1'b0, last_q} + ONE_W;
    rot   = {req, req} >> shamt;
    off   = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (rot[i]) off = (SEL_W+1)'(i);
    end
    pick_sum = shamt + off;
    if (pick_sum >= NCH_W) pick_sum = pick_sum - NCH_W;
    pick = pick_sum[SEL_W-1:0];
  end

  assign burst_eff = (burst_q == 8'd0) ? 9'd1 : {1'b0, burst_q};
  assign bcnt_inc  = {1'b0, bcnt_q} + 9'd1;
  assign beat_end  = (state_q == PASS) & s_tvalid[sel_q] & m_tready & s_tlast[sel_q];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    bcnt_d   = bcnt_q;
    pkt_d    = pkt_count;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tuser  = 3'd0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          bcnt_d  = 8'd0;
          state_d = PASS;
        end
      end
      PASS: begin
        m_tvalid        = s_tvalid[sel_q];
        m_tlast         = s_tlast[sel_q];
        m_tdata         = ch_data[sel_q];
        m_tuser         = 3'(sel_q);
        s_tready[sel_q] = m_tready;
        if (beat_end) begin
          pkt_d = pkt_count + 32'd1;
          // A channel masked off mid-burst loses the grant at its next packet end.
          if (bcnt_inc < burst_eff && mask_q[sel_q]) begin
            bcnt_d = bcnt_q + 8'd1;
          end else begin
            last_d  = sel_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= SEL_W'(NUM_CH-1);
      bcnt_q    <= 8'd0;
      pkt_count <= 32'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      pkt_count <= pkt_d;
    end
  end

endmodule

// File: tb/tb_chanmux_sched.sv
// Randomized scoreboard bench for chanmux_sched: a packet-level round-robin
// model predicts the output beat stream; a monitor pops and compares beats.
module tb_chanmux_sched;
  localparam int         NUM_CH     = 4;
  localparam int         WIDTH      = 32;
  localparam logic [7:0] SR_CH_MASK = 8'd128;
  localparam logic [7:0] SR_BURST   = 8'd129;

  logic                    ce_clk, ce_rst_n;
  logic                    set_stb;
  logic [7:0]              set_addr;
  logic [31:0]             set_data;
  logic [NUM_CH*WIDTH-1:0] s_tdata;
  logic [NUM_CH-1:0]       s_tlast, s_tvalid, s_tready;
  logic [WIDTH-1:0]        m_tdata;
  logic                    m_tlast, m_tvalid, m_tready;
  logic [2:0]              m_tuser;
  logic [31:0]             pkt_count;

  chanmux_sched #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SR_CH_MASK(SR_CH_MASK), .SR_BURST(SR_BURST)) dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .pkt_count(pkt_count)
  );

  // Source beats {last, data} per channel; gen_q is the model's copy of the same packets.
  logic [WIDTH:0]   src_q [NUM_CH][$];
  logic [WIDTH:0]   gen_q [NUM_CH][$];
  logic [WIDTH+3:0] exp_q [$];
  logic [NUM_CH-1:0] mid, hs, m_mask;
  logic              gap_en, gap_chk, in_pkt;
  int                ready_mode, m_burst, m_last;
  logic [31:0]       m_pkts;
  int                n_cmp, n_bad, cyc, obs_pkts, last_end;

  initial begin
    ce_clk = 1'b0;
    forever #5 ce_clk = ~ce_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Driver: retire handshaken beats, then present the next beat of each channel.
  initial begin
    logic [WIDTH:0] b;
    forever begin
      @(posedge ce_clk); #1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (hs[k] && src_q[k].size() > 0) begin
          b = src_q[k].pop_front();
          mid[k] = !b[WIDTH];
        end
      end
      hs = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (src_q[k].size() > 0) begin
          b = src_q[k][0];
          s_tdata[k*WIDTH +: WIDTH] = b[WIDTH-1:0];
          s_tlast[k]  = b[WIDTH];
          s_tvalid[k] = !(gap_en && mid[k] && ($urandom_range(3) == 0));
        end else begin
          s_tdata[k*WIDTH +: WIDTH] = '0;
          s_tlast[k]  = 1'b0;
          s_tvalid[k] = 1'b0;
        end
      end
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(3) != 0);
        default: m_tready = ~m_tready;
      endcase
    end
  end

  // Monitor: compares every output transfer against the scoreboard queue.
  initial begin
    logic [7:0]       exp_rdy;
    logic [WIDTH+3:0] e;
    forever begin
      @(negedge ce_clk);
      cyc++;
      if (ce_rst_n) begin
        hs = s_tvalid & s_tready;
        if (m_tvalid) begin
          exp_rdy = '0;
          exp_rdy[m_tuser] = m_tready;
          check("s_tready_mirror", {4'b0, s_tready}, exp_rdy);
          if (m_tready) begin
            if (exp_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_beat: got tuser=%0d data=%0h, expected no beat", m_tuser, m_tdata);
            end else begin
              e = exp_q.pop_front();
              check("beat{tuser,last,data}", {m_tuser, m_tlast, m_tdata}, e);
            end
            if (!in_pkt && gap_chk && obs_pkts > 0) check("idle_gap", cyc - last_end, 2);
            in_pkt = !m_tlast;
            if (m_tlast) begin
              obs_pkts++;
              last_end = cyc;
            end
          end
        end
      end
    end
  end

  task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
    @(negedge ce_clk);
    set_stb = 1'b1; set_addr = addr; set_data = data;
    @(negedge ce_clk);
    set_stb = 1'b0;
  endtask

  task automatic load_pkts(input int ch, input int n, input int len);
    int l;
    logic [WIDTH:0] e;
    for (int p = 0; p < n; p++) begin
      l = (len > 0) ? len : int'($urandom_range(1, 4));
      for (int b = 0; b < l; b++) begin
        e = {(b == l-1), WIDTH'($urandom)};
        src_q[ch].push_back(e);
        gen_q[ch].push_back(e);
      end
    end
  endtask

  task automatic expect_pkts(input int ch, input int n);
    logic [WIDTH:0] e;
    for (int p = 0; p < n; p++) begin
      e = '0;
      while (gen_q[ch].size() > 0 && !e[WIDTH]) begin
        e = gen_q[ch].pop_front();
        exp_q.push_back({3'(ch), e});
      end
      m_pkts = m_pkts + 32'd1;
    end
    m_last = ch;
  endtask

  // Grants go to the first enabled channel with packets after the previous grant;
  // each grant carries max(burst,1) packets.
  task automatic model_rr();
    int c, k, be;
    be = (m_burst == 0) ? 1 : m_burst;
    c = 0;
    while (c >= 0) begin
      c = -1;
      for (int o = 1; o <= NUM_CH; o++) begin
        k = (m_last + o) % NUM_CH;
        if (c < 0 && m_mask[k] && gen_q[k].size() > 0) c = k;
      end
      if (c >= 0) expect_pkts(c, be);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < budget) begin
      @(posedge ce_clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge ce_clk);
  endtask

  task automatic wait_below(input int n);
    int t;
    t = 0;
    while (exp_q.size() >= n && t < 200) begin
      @(posedge ce_clk);
      t++;
    end
    if (exp_q.size() >= n) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: %0d beats outstanding, expected fewer than %0d", exp_q.size(), n);
    end
  endtask

  task automatic flush_blocked();
    @(negedge ce_clk);
    for (int k = 0; k < NUM_CH; k++) begin
      if (!m_mask[k]) begin
        src_q[k].delete();
        gen_q[k].delete();
        mid[k] = 1'b0;
      end
    end
  endtask

  task automatic run_phase(input logic [31:0] mask, input logic [31:0] burst, input int fixed_g,
                           input int rmode, input logic gapen, input logic do_cfg);
    int be, n;
    if (do_cfg) begin
      write_reg(SR_CH_MASK, mask);
      write_reg(SR_BURST, burst);
    end
    m_mask = mask[NUM_CH-1:0];
    m_burst = int'(burst[7:0]);
    be = (m_burst == 0) ? 1 : m_burst;
    ready_mode = rmode;
    gap_en = gapen;
    @(negedge ce_clk);
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_mask[k]) n = ((fixed_g >= 0) ? fixed_g : int'($urandom_range(2))) * be;
      else n = int'($urandom_range(2));
      load_pkts(k, n, 0);
    end
    model_rr();
    wait_drain(3000);
    flush_blocked();
    check("pkt_count", pkt_count, m_pkts);
  endtask

  initial begin
    int t;
    n_cmp = 0; n_bad = 0; cyc = 0; obs_pkts = 0; last_end = 0;
    in_pkt = 1'b0; gap_chk = 1'b0; gap_en = 1'b0; ready_mode = 0;
    mid = '0; hs = '0; m_pkts = '0; m_mask = '1; m_burst = 1; m_last = NUM_CH-1;
    ce_rst_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    s_tdata = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b1;

    repeat (3) @(negedge ce_clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_pkt_count", pkt_count, 0);
    ce_rst_n = 1'b1;
    repeat (2) @(negedge ce_clk);

    // Default settings, all channels 2-beat packets back to back.
    gap_chk = 1'b1; obs_pkts = 0;
    for (int k = 0; k < NUM_CH; k++) load_pkts(k, 2, 2);
    model_rr();
    t = 0;
    while (obs_pkts < 4 && t < 200) begin
      @(posedge ce_clk);
      t++;
    end
    @(negedge ce_clk);
    check("pkt_count_round1", pkt_count, 4);
    wait_drain(1000);
    gap_chk = 1'b0;
    check("pkt_count_round2", pkt_count, m_pkts);

    // burst=3 on channels 0 and 2.
    run_phase(32'h5, 32'd3, 2, 1, 1'b1, 1'b1);

    // Mask change during a ch0 packet.
    write_reg(SR_CH_MASK, 32'hF);
    write_reg(SR_BURST, 32'd1);
    m_mask = 4'hF; m_burst = 1; ready_mode = 0; gap_en = 1'b0;
    @(negedge ce_clk);
    load_pkts(0, 1, 6);
    expect_pkts(0, 1);
    wait_below(6);
    write_reg(SR_CH_MASK, 32'h2);
    m_mask = 4'h2;
    load_pkts(0, 1, 0); load_pkts(1, 2, 0); load_pkts(2, 1, 0); load_pkts(3, 1, 0);
    model_rr();
    wait_drain(1000);
    flush_blocked();
    check("pkt_count_maskchg", pkt_count, m_pkts);

    // Toggling m_tready while ch1 is granted.
    run_phase(32'h2, 32'd1, 2, 2, 1'b0, 1'b1);

    // mask=0 holds everything off; enabling ch3 grants it two cycles after the strobe.
    write_reg(SR_CH_MASK, 32'h0);
    m_mask = '0; ready_mode = 0;
    @(negedge ce_clk);
    for (int k = 0; k < NUM_CH; k++) load_pkts(k, 1, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge ce_clk);
      check("mask0_m_tvalid", m_tvalid, 0);
      check("mask0_s_tready", s_tready, 0);
    end
    expect_pkts(3, 1);
    m_mask = 4'h8;
    write_reg(SR_CH_MASK, 32'h8);
    check("mask8_arb_cycle_valid", m_tvalid, 0);
    @(negedge ce_clk);
    check("mask8_grant_valid", m_tvalid, 1);
    check("mask8_grant_tuser", m_tuser, 3);
    wait_drain(200);
    flush_blocked();
    check("pkt_count_mask8", pkt_count, m_pkts);

    for (int r = 0; r < 8; r++)
      run_phase(32'($urandom_range(1, 15)), 32'($urandom_range(0, 3)), -1, 1, 1'b1, 1'b1);

    // Reset in the middle of a ch2 packet.
    write_reg(SR_CH_MASK, 32'hF);
    write_reg(SR_BURST, 32'd2);
    m_mask = 4'hF; m_burst = 2; ready_mode = 0; gap_en = 1'b0;
    @(negedge ce_clk);
    load_pkts(2, 1, 6);
    expect_pkts(2, 1);
    wait_below(5);
    @(negedge ce_clk);
    #2 ce_rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tdata", m_tdata, 0);
    check("midrst_m_tuser", m_tuser, 0);
    check("midrst_pkt_count", pkt_count, 0);
    for (int k = 0; k < NUM_CH; k++) begin
      src_q[k].delete();
      gen_q[k].delete();
    end
    exp_q.delete();
    mid = '0; hs = '0; m_last = NUM_CH-1; m_mask = '1; m_burst = 1; m_pkts = '0;
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    run_phase(32'hF, 32'd1, 1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
